// File: rtl/channel_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// channel_sweep_ctrl_if
//   Bundles the sweep controller's request/configuration inputs and its
//   channel-control / measurement-attribution outputs.
//
//   master : requester side (drives start/abort/config, samples status)
//   slave  : controller side (channel_sweep_ctrl)
//
//   sym_clk_ena  one-cycle symbol strobe
//   start/abort  sweep request / termination
//   gain_mask    gains included in the sweep (bit g -> gain_set g)
//   noise_steps  run each gain twice (awgn off, then on)
//   settle_syms  symbols to wait after each configuration change
//   meas_syms    symbols per measurement window (0 treated as 1)
//   gain_set, awgn_en        channel configuration
//   meas_en, step_done       measurement window / end-of-step pulse
//   step_idx, busy, done     sweep status
// -----------------------------------------------------------------------------
interface channel_sweep_ctrl_if #(
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 8
);
    logic                sym_clk_ena;
    logic                start;
    logic                abort;
    logic [3:0]          gain_mask;
    logic                noise_steps;
    logic [SETTLE_W-1:0] settle_syms;
    logic [CNT_W-1:0]    meas_syms;

    logic [1:0]          gain_set;
    logic                awgn_en;
    logic                meas_en;
    logic                step_done;
    logic [2:0]          step_idx;
    logic                busy;
    logic                done;

    modport master (
        output sym_clk_ena, start, abort, gain_mask, noise_steps,
               settle_syms, meas_syms,
        input  gain_set, awgn_en, meas_en, step_done, step_idx, busy, done
    );

    modport slave (
        input  sym_clk_ena, start, abort, gain_mask, noise_steps,
               settle_syms, meas_syms,
        output gain_set, awgn_en, meas_en, step_done, step_idx, busy, done
    );
endinterface

// File: rtl/channel_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// channel_sweep_ctrl
//   Steps the channel model through the enabled gains (ascending), optionally
//   running each with AWGN off then on. After every configuration change it
//   waits settle_syms symbol strobes, then opens a measurement window of
//   max(meas_syms,1) strobes and pulses step_done when the window closes.
//
//   clk    system clock
//   reset  synchronous, active-high
//   sweep  channel_sweep_ctrl_if slave modport (config in, status out)
// -----------------------------------------------------------------------------
module channel_sweep_ctrl #(
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    channel_sweep_ctrl_if.slave  sweep
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t              r_state;

    // Configuration captured when start is accepted
    logic [3:0]          r_mask;
    logic                r_noise;
    logic [SETTLE_W-1:0] r_settle;
    logic [CNT_W-1:0]    r_meas;

    logic [SETTLE_W-1:0] r_scnt;
    logic [CNT_W-1:0]    r_mcnt;

    logic [1:0]          r_gain;
    logic                r_awgn;
    logic                r_meas_en;
    logic                r_step_done;
    logic [2:0]          r_step_idx;
    logic                r_busy;
    logic                r_done;

    logic                w_first_found;
    logic [1:0]          w_first_gain;
    logic                w_above_found;
    logic [1:0]          w_above_gain;
    logic                w_noise_next;
    logic                w_has_next;
    logic [1:0]          w_next_gain;
    logic [CNT_W-1:0]    w_meas_n;

    // Lowest enabled gain of the live mask (first step) and lowest latched
    // gain strictly above the current one (next gain).
    always_comb begin
        w_first_found = 1'b0;
        w_first_gain  = '0;
        w_above_found = 1'b0;
        w_above_gain  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sweep.gain_mask[i] && !w_first_found) begin
                w_first_found = 1'b1;
                w_first_gain  = 2'(i);
            end
            if (r_mask[i] && (2'(i) > r_gain) && !w_above_found) begin
                w_above_found = 1'b1;
                w_above_gain  = 2'(i);
            end
        end
    end

    assign w_noise_next = r_noise && !r_awgn;
    assign w_has_next   = w_noise_next || w_above_found;
    assign w_next_gain  = w_noise_next ? r_gain : w_above_gain;
    assign w_meas_n     = (sweep.meas_syms == '0) ? CNT_W'(1) : sweep.meas_syms;

    always_ff @(posedge clk) begin
        if (reset || sweep.abort) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_noise     <= 1'b0;
            r_settle    <= '0;
            r_meas      <= '0;
            r_scnt      <= '0;
            r_mcnt      <= '0;
            r_gain      <= '0;
            r_awgn      <= 1'b0;
            r_meas_en   <= 1'b0;
            r_step_done <= 1'b0;
            r_step_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (sweep.start) begin
                        r_mask   <= sweep.gain_mask;
                        r_noise  <= sweep.noise_steps;
                        r_settle <= sweep.settle_syms;
                        r_meas   <= w_meas_n;
                        r_scnt   <= '0;
                        r_mcnt   <= '0;
                        if (!w_first_found) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_gain     <= w_first_gain;
                            r_awgn     <= 1'b0;
                            r_step_idx <= '0;
                            r_busy     <= 1'b1;
                            r_done     <= 1'b0;
                            r_meas_en  <= 1'b0;
                            r_state    <= (sweep.settle_syms == '0) ? ST_MEASURE : ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (sweep.sym_clk_ena) begin
                        if (r_scnt == r_settle - SETTLE_W'(1)) begin
                            r_state   <= ST_MEASURE;
                            r_meas_en <= 1'b1;
                            r_mcnt    <= '0;
                        end else begin
                            r_scnt <= r_scnt + SETTLE_W'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    if (!r_meas_en) begin
                        // Entered directly without settling: open the window
                        // one cycle after entry so every counted strobe is
                        // seen with meas_en=1 downstream.
                        r_meas_en <= 1'b1;
                    end else if (sweep.sym_clk_ena) begin
                        if (r_mcnt == r_meas - CNT_W'(1)) begin
                            r_step_done <= 1'b1;
                            r_meas_en   <= 1'b0;
                            r_mcnt      <= '0;
                            r_scnt      <= '0;
                            if (w_has_next) begin
                                r_gain     <= w_next_gain;
                                r_awgn     <= w_noise_next;
                                r_step_idx <= r_step_idx + 3'd1;
                                r_state    <= (r_settle == '0) ? ST_MEASURE : ST_SETTLE;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_mcnt <= r_mcnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sweep.gain_set  = r_gain;
    assign sweep.awgn_en   = r_awgn;
    assign sweep.meas_en   = r_meas_en;
    assign sweep.step_done = r_step_done;
    assign sweep.step_idx  = r_step_idx;
    assign sweep.busy      = r_busy;
    assign sweep.done      = r_done;
endmodule

// File: tb/tb_channel_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_channel_sweep_ctrl
//   Directed bench for channel_sweep_ctrl. A free-running strobe source
//   pulses sym_clk_ena every 4 cycles; a negedge monitor logs each step's
//   (gain, awgn, idx), window strobe count, settle strobe count and done.
// -----------------------------------------------------------------------------
module tb_channel_sweep_ctrl;
    logic clk;
    logic reset;
    logic strobe_on;

    int errors = 0;
    int checks = 0;

    channel_sweep_ctrl_if #(.CNT_W(16), .SETTLE_W(8)) sif ();

    channel_sweep_ctrl #(.CNT_W(16), .SETTLE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sweep (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Symbol strobe: one cycle in four, changed just after the rising edge
    initial begin
        int ph;
        ph = 0;
        sif.sym_clk_ena = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sif.sym_clk_ena = strobe_on && (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    // Monitor
    int   mon_pulses, n_rise, win, settle_cnt;
    logic prev_meas, busy_seen;
    logic [1:0] last_gain;
    logic last_awgn;
    logic [2:0] last_idx;
    int   rec_gain [16];
    int   rec_awgn [16];
    int   rec_idx  [16];
    int   rec_win  [16];
    int   rec_done [16];
    int   rec_settle [16];

    always @(negedge clk) begin
        if (sif.busy === 1'b1) busy_seen = 1'b1;
        if (sif.step_done === 1'b1) begin
            if (mon_pulses < 16) begin
                rec_gain[mon_pulses] = int'(last_gain);
                rec_awgn[mon_pulses] = int'(last_awgn);
                rec_idx[mon_pulses]  = int'(last_idx);
                rec_win[mon_pulses]  = win;
                rec_done[mon_pulses] = int'(sif.done);
            end
            mon_pulses++;
            win = 0;
            settle_cnt = 0;
        end
        if (sif.meas_en === 1'b1 && prev_meas === 1'b0) begin
            if (n_rise < 16) rec_settle[n_rise] = settle_cnt;
            n_rise++;
            settle_cnt = 0;
        end
        if (sif.sym_clk_ena === 1'b1) begin
            if (sif.meas_en === 1'b1) begin
                win++;
                last_gain = sif.gain_set;
                last_awgn = sif.awgn_en;
                last_idx  = sif.step_idx;
            end else if (sif.busy === 1'b1) begin
                settle_cnt++;
            end
        end
        prev_meas = sif.meas_en;
    end

    task automatic clear_mon();
        mon_pulses = 0;
        n_rise     = 0;
        win        = 0;
        settle_cnt = 0;
        busy_seen  = 1'b0;
        prev_meas  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_gain"},  32'(sif.gain_set),  0);
        check({tag, "_awgn"},  32'(sif.awgn_en),   0);
        check({tag, "_meas"},  32'(sif.meas_en),   0);
        check({tag, "_sdone"}, 32'(sif.step_done), 0);
        check({tag, "_idx"},   32'(sif.step_idx),  0);
        check({tag, "_busy"},  32'(sif.busy),      0);
        check({tag, "_done"},  32'(sif.done),      0);
    endtask

    task automatic start_sweep(input logic [3:0] m, input logic n,
                               input logic [7:0] s, input logic [15:0] ms);
        sif.gain_mask   = m;
        sif.noise_steps = n;
        sif.settle_syms = s;
        sif.meas_syms   = ms;
        clear_mon();
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int c;
        c = 0;
        while (sif.done !== 1'b1 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done_in_time"}, 32'(sif.done), 1);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        logic fired;
        int c;

        strobe_on       = 1'b1;
        reset           = 1'b1;
        sif.start       = 1'b0;
        sif.abort       = 1'b0;
        sif.gain_mask   = '0;
        sif.noise_steps = 1'b0;
        sif.settle_syms = '0;
        sif.meas_syms   = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Full sweep: 4 gains x 2 noise settings
        start_sweep(4'b1111, 1'b1, 8'd2, 16'd4);
        check("s1_busy_t1", 32'(sif.busy), 1);
        check("s1_idx_t1",  32'(sif.step_idx), 0);
        wait_done("s1", 1000);
        check("s1_pulses", 32'(mon_pulses), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s1_gain[%0d]", i),   32'(rec_gain[i]), 32'(i / 2));
            check($sformatf("s1_awgn[%0d]", i),   32'(rec_awgn[i]), 32'(i % 2));
            check($sformatf("s1_idx[%0d]", i),    32'(rec_idx[i]),  32'(i));
            check($sformatf("s1_win[%0d]", i),    32'(rec_win[i]),  4);
            check($sformatf("s1_settle[%0d]", i), 32'(rec_settle[i]), 2);
            check($sformatf("s1_done[%0d]", i),   32'(rec_done[i]), (i == 7) ? 1 : 0);
        end
        check("s1_busy_end", 32'(sif.busy), 0);
        check("s1_hold_gain", 32'(sif.gain_set), 3);
        check("s1_hold_awgn", 32'(sif.awgn_en), 1);

        // Sparse mask, no settle, meas_syms=0 treated as 1
        start_sweep(4'b1010, 1'b0, 8'd0, 16'd0);
        check("s2_gain_t1", 32'(sif.gain_set), 1);
        check("s2_done_t1", 32'(sif.done), 0);
        wait_done("s2", 500);
        check("s2_pulses", 32'(mon_pulses), 2);
        check("s2_gain[0]", 32'(rec_gain[0]), 1);
        check("s2_gain[1]", 32'(rec_gain[1]), 3);
        check("s2_awgn[1]", 32'(rec_awgn[1]), 0);
        check("s2_idx[1]",  32'(rec_idx[1]), 1);
        check("s2_win[0]",  32'(rec_win[0]), 1);
        check("s2_win[1]",  32'(rec_win[1]), 1);

        // Empty mask
        start_sweep(4'b0000, 1'b1, 8'd2, 16'd4);
        check("s3_done_t1", 32'(sif.done), 1);
        check("s3_busy_t1", 32'(sif.busy), 0);
        repeat (5) @(negedge clk);
        check("s3_pulses", 32'(mon_pulses), 0);
        check("s3_busy_seen", 32'(busy_seen), 0);
        check("s3_done_hold", 32'(sif.done), 1);

        // Abort on the cycle carrying the final strobe of step 3
        start_sweep(4'b1111, 1'b1, 8'd2, 16'd4);
        seen  = 0;
        fired = 1'b0;
        c     = 0;
        while (!fired && c < 2000) begin
            @(negedge clk);
            c++;
            if (sif.step_idx === 3'd3 && sif.meas_en === 1'b1 && sif.sym_clk_ena === 1'b1) begin
                if (seen == 3) begin
                    sif.abort = 1'b1;
                    fired = 1'b1;
                end else begin
                    seen++;
                end
            end
        end
        check("s4_abort_reached", 32'(fired), 1);
        check("s4_gain_before", 32'(sif.gain_set), 1);
        @(negedge clk);
        sif.abort = 1'b0;
        check_idle_zero("s4_after_abort");
        repeat (3) @(negedge clk);
        check("s4_pulses", 32'(mon_pulses), 3);
        start_sweep(4'b1111, 1'b1, 8'd2, 16'd4);
        check("s4_restart_idx",  32'(sif.step_idx), 0);
        check("s4_restart_busy", 32'(sif.busy), 1);
        sif.abort = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;

        // Start and config changes during a sweep are ignored
        start_sweep(4'b0011, 1'b0, 8'd1, 16'd4);
        repeat (10) @(negedge clk);
        sif.meas_syms = 16'd9;
        sif.gain_mask = 4'b1100;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        check("s5_idx_mid",  32'(sif.step_idx), 0);
        check("s5_busy_mid", 32'(sif.busy), 1);
        wait_done("s5", 1000);
        check("s5_pulses",  32'(mon_pulses), 2);
        check("s5_gain[1]", 32'(rec_gain[1]), 1);
        check("s5_win[0]",  32'(rec_win[0]), 4);
        check("s5_win[1]",  32'(rec_win[1]), 4);

        // Reset during SETTLE, then start+abort together
        start_sweep(4'b1111, 1'b1, 8'd5, 16'd4);
        repeat (3) @(negedge clk);
        check("s6_busy_settle", 32'(sif.busy), 1);
        check("s6_meas_settle", 32'(sif.meas_en), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero("s6_after_reset");
        clear_mon();
        sif.gain_mask = 4'b1111;
        sif.start = 1'b1;
        sif.abort = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        check_idle_zero("s6_start_abort");
        repeat (3) @(negedge clk);
        check("s6_busy_seen", 32'(busy_seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/channel_sweep_ctrl.md
# channel_sweep_ctrl

- Sequences the channel model through a programmable sweep of gain settings, each optionally run without and then with AWGN.
- Drives the channel's `gain_set` and `awgn_en` inputs.
- Counts symbol strobes to insert a settle interval after every configuration change, then opens a measurement window of fixed symbol length.
- Downstream error counters use `meas_en` and `step_done` to attribute results to each step.

## Interface
Parameters:
- `CNT_W`, default 16: width of the measurement-length symbol counter.
- `SETTLE_W`, default 8: width of the settle-length symbol counter.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high.
- `sym_clk_ena`  in  1: one-cycle symbol strobe; all symbol counting uses it.
- `start`  in  1: sweep request pulse.
- `abort`  in  1: terminates the sweep.
- `gain_mask`  in  4: bit g set means gain_set value g is included in the sweep.
- `noise_steps`  in  1: 1 means each enabled gain runs twice (awgn_en=0, then awgn_en=1); 0 means awgn_en=0 only.
- `settle_syms`  in  SETTLE_W: symbols to wait after each configuration change.
- `meas_syms`  in  CNT_W: symbols per measurement window; 0 is treated as 1.
- `gain_set`  out  2: to channel.
- `awgn_en`  out  1: to channel.
- `meas_en`  out  1: high during the measurement window.
- `step_done`  out  1: one-cycle pulse at the end of each window.
- `step_idx`  out  3: ordinal of the current step, 0..7.
- `busy`  out  1: high while a sweep is running.
- `done`  out  1: sweep-complete level.

## Operation
- States: IDLE, SETTLE, MEASURE, DONE.
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- Step order is ascending gain, 0→3, skipping gains whose mask bit is clear. Within each gain: awgn 0, then awgn 1 if noise_steps=1.
- `gain_mask`, `noise_steps`, `settle_syms` and `meas_syms` are latched on the cycle `start` is accepted. Input changes during a sweep have no effect.
- IDLE/DONE + `start`:
  - gain_mask=0: go to DONE. busy stays 0, done=1, no step_done pulse.
  - Otherwise: load the first step. gain_set = lowest enabled gain, awgn_en=0, step_idx=0, busy=1, done=0.
  - Next state is SETTLE, or MEASURE if settle_syms=0.
- SETTLE:
  - Count sym_clk_ena pulses.
  - On the cycle carrying the settle_syms-th strobe, go to MEASURE.
  - meas_en=1 from the following cycle.
- MEASURE:
  - meas_en=1. Count strobes.
  - On the cycle carrying the meas_syms-th strobe (N = max(meas_syms,1)), the following cycle has step_done=1 and meas_en=0.
  - If a further step exists, that same following cycle also loads the next gain_set/awgn_en and step_idx+1, and the state becomes SETTLE (or MEASURE if settle_syms=0).
  - If no further step exists: state DONE, busy=0, done=1. gain_set/awgn_en hold the last step's values.
- DONE: done stays 1 until the next accepted `start`, `abort`, or `reset`.
- `start` while busy=1 is ignored.
- `abort` in any state:
  - Next cycle: IDLE with all outputs 0.
  - No step_done pulse, including an abort in the cycle a window would complete.
  - `abort` has priority over a coincident `start`.
- `reset` mid-sweep behaves like `abort`.
- A strobe in the same cycle as the state transition into SETTLE/MEASURE is not counted. Counting starts with the first strobe after entry.
- Counters clear on every state entry. No counter saturation or wrap is possible within the latched limits.

## Timing
- Accepted start at cycle t:
  - Outputs at t+1: new config and busy.
  - meas_en rises one cycle after the last settle strobe.
  - meas_en falls, together with the step_done pulse, one cycle after the last measure strobe.
- A window contains exactly N strobes with meas_en=1.
- For settle_syms = S ≥ 1, exactly S strobes elapse between a config change and meas_en rising.
- `step_done` is high for exactly 1 cycle per completed step. Total pulses per sweep = popcount(gain_mask) × (1 + noise_steps).
- `done` rises in the same cycle as the final step_done.

## Test plan
- mask=4'b1111, noise_steps=1, settle=2, meas=4, strobe every 4 cycles → 8 step_done pulses. (gain,awgn) sequence: (0,0),(0,1),(1,0)…(3,1). step_idx 0..7. Each window spans exactly 4 strobes; done=1 with the last pulse.
- mask=4'b1010, noise_steps=0, settle=0, meas=0 → steps gain 1 then gain 3. Each window lasts 1 strobe; meas_en rises the cycle after entry; 2 pulses.
- mask=0, start → done=1 next cycle, busy never 1, no step_done.
- abort asserted in the cycle carrying the final measure strobe of step 3 → no step_done. Next cycle: IDLE, all outputs 0. A subsequent start restarts at step_idx 0.
- start pulsed mid-sweep, plus meas_syms changed from 4 to 9 during the sweep → ignored. Windows remain 4 strobes.
- reset asserted during SETTLE → all outputs 0 the next cycle. start+abort in the same cycle → stays IDLE.
